// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction, extracts load data and
// drives the register-file write port, the decode forwarding tap and the debug trace.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic        ms_res_from_mem,
    input  logic [2:0]  ms_ld_type,
    input  logic [31:0] ms_alu_result,
    input  logic [31:0] ms_mem_rdata,
    input  logic        ws_hold,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_valid,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    logic        ws_valid_q, ws_valid_d;
    logic [31:0] pc_q, pc_d;
    logic        gr_we_q, gr_we_d;
    logic [4:0]  dest_q, dest_d;
    logic        res_from_mem_q, res_from_mem_d;
    logic [2:0]  ld_type_q, ld_type_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        ws_ready_go;
    logic        accept;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] final_data;
    logic        wr;

    // Handshake: an offer transfers on the edge where ms_to_ws_valid && ws_allowin;
    // the stage retires on any edge with ws_valid && !ws_hold, so retire and
    // accept may share an edge. While held, the offer must stay stable.
    always_comb begin
        ws_ready_go    = !ws_hold;
        ws_allowin     = !ws_valid_q || ws_ready_go;
        accept         = ms_to_ws_valid && ws_allowin;
        ws_valid_d     = ws_valid_q;
        pc_d           = pc_q;
        gr_we_d        = gr_we_q;
        dest_d         = dest_q;
        res_from_mem_d = res_from_mem_q;
        ld_type_d      = ld_type_q;
        alu_result_d   = alu_result_q;
        mem_rdata_d    = mem_rdata_q;
        if (accept) begin
            ws_valid_d     = 1'b1;
            pc_d           = ms_pc;
            gr_we_d        = ms_gr_we;
            dest_d         = ms_dest;
            res_from_mem_d = ms_res_from_mem;
            ld_type_d      = ms_ld_type;
            alu_result_d   = ms_alu_result;
            mem_rdata_d    = ms_mem_rdata;
        end else if (ws_ready_go) begin
            ws_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q     <= 1'b0;
            pc_q           <= '0;
            gr_we_q        <= 1'b0;
            dest_q         <= '0;
            res_from_mem_q <= 1'b0;
            ld_type_q      <= '0;
            alu_result_q   <= '0;
            mem_rdata_q    <= '0;
        end else begin
            ws_valid_q     <= ws_valid_d;
            pc_q           <= pc_d;
            gr_we_q        <= gr_we_d;
            dest_q         <= dest_d;
            res_from_mem_q <= res_from_mem_d;
            ld_type_q      <= ld_type_d;
            alu_result_q   <= alu_result_d;
            mem_rdata_q    <= mem_rdata_d;
        end
    end

    // Half-word lane ignores address bit 0 (misaligned halves are not trapped here).
    always_comb begin
        ld_byte = mem_rdata_q[7:0];
        case (alu_result_q[1:0])
            2'd0: ld_byte = mem_rdata_q[7:0];
            2'd1: ld_byte = mem_rdata_q[15:8];
            2'd2: ld_byte = mem_rdata_q[23:16];
            2'd3: ld_byte = mem_rdata_q[31:24];
            default: ld_byte = mem_rdata_q[7:0];
        endcase
        ld_half = alu_result_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
        case (ld_type_q)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {24'd0, ld_byte};
            LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata_q;
        endcase
        final_data = res_from_mem_q ? ld_data : alu_result_q;
        wr         = ws_valid_q && gr_we_q && (dest_q != 5'd0);
    end

    // The tap ignores ws_hold so decode can bypass from a held instruction.
    assign rf_we             = wr && ws_ready_go;
    assign rf_waddr          = dest_q;
    assign rf_wdata          = final_data;
    assign ws_fwd_valid      = wr;
    assign ws_fwd_dest       = dest_q;
    assign ws_fwd_data       = final_data;
    assign debug_wb_pc       = ws_valid_q ? pc_q : 32'd0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = final_data;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: driver tasks push expected writes into a queue,
// a monitor pops and compares on every rf_we cycle.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic        ms_res_from_mem;
    logic [2:0]  ms_ld_type;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_mem_rdata;
    logic        ws_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc[68:37], dest[36:32], data[31:0]}
    logic [68:0] exp_q[$];

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_res_from_mem   (ms_res_from_mem),
        .ms_ld_type        (ms_ld_type),
        .ms_alu_result     (ms_alu_result),
        .ms_mem_rdata      (ms_mem_rdata),
        .ws_hold           (ws_hold),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_valid      (ws_fwd_valid),
        .ws_fwd_dest       (ws_fwd_dest),
        .ws_fwd_data       (ws_fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rf_we_waddr", {27'd0, rf_waddr}, 32'hffff_ffff);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                check("wb_pc",     debug_wb_pc,               e[68:37]);
                check("wb_waddr",  {27'd0, rf_waddr},         {27'd0, e[36:32]});
                check("wb_wdata",  rf_wdata,                  e[31:0]);
                check("wb_dbg_we", {28'd0, debug_wb_rf_we},   32'h0000_000f);
                check("wb_dbg_wnum_wdata",
                      {debug_wb_rf_wnum == e[36:32], debug_wb_rf_wdata == e[31:0]} == 2'b11 ? 32'd1 : 32'd0,
                      32'd1);
            end
        end else if (rf_we !== 1'b0 && !reset) begin
            check("rf_we_unknown", {31'd0, rf_we}, 32'd0);
        end
    end

    // Driver tasks
    task automatic set_inputs(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                              input logic rfm, input logic [2:0] ld,
                              input logic [31:0] alu, input logic [31:0] rdata);
        ms_to_ws_valid  = 1'b1;
        ms_pc           = pc;
        ms_gr_we        = gr_we;
        ms_dest         = dest;
        ms_res_from_mem = rfm;
        ms_ld_type      = ld;
        ms_alu_result   = alu;
        ms_mem_rdata    = rdata;
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                        input logic rfm, input logic [2:0] ld,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] exp_data, output int waited);
        logic ok;
        waited = 0;
        set_inputs(pc, gr_we, dest, rfm, ld, alu, rdata);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = ws_allowin;
            if (ok && gr_we && dest != 5'd0) exp_q.push_back({pc, dest, exp_data});
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
        end
        if (waited >= 20) check("send_timeout", 32'd20, 32'd0);
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        int w;
        reset           = 1'b1;
        ms_to_ws_valid  = 1'b0;
        ms_pc           = '0;
        ms_gr_we        = 1'b0;
        ms_dest         = '0;
        ms_res_from_mem = 1'b0;
        ms_ld_type      = '0;
        ms_alu_result   = '0;
        ms_mem_rdata    = '0;
        ws_hold         = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_allowin", {31'd0, ws_allowin}, 32'd1);
        check("rst_rf", {rf_we, rf_waddr, 26'd0} | rf_wdata, 32'd0);
        check("rst_fwd", {ws_fwd_valid, ws_fwd_dest, 26'd0} | ws_fwd_data, 32'd0);
        check("rst_dbg_pc", debug_wb_pc, 32'd0);
        check("rst_dbg", {debug_wb_rf_we, debug_wb_rf_wnum, 23'd0} | debug_wb_rf_wdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU write
        send(32'h1c000000, 1'b1, 5'd5, 1'b0, 3'd0, 32'h12345678, 32'h0, 32'h12345678, w);
        @(negedge clk);
        check("alu_rf_we", {31'd0, rf_we}, 32'd1);
        check("alu_fwd", {26'd0, ws_fwd_valid, ws_fwd_dest}, 32'h25);
        @(posedge clk);
        #1;

        // Load extraction
        send(32'h1c000010, 1'b1, 5'd10, 1'b1, 3'd1, 32'h10000001, RD, 32'h0000007F, w);
        send(32'h1c000014, 1'b1, 5'd11, 1'b1, 3'd1, 32'h10000002, RD, 32'hFFFFFFFF, w);
        send(32'h1c000018, 1'b1, 5'd12, 1'b1, 3'd2, 32'h10000003, RD, 32'h00000080, w);
        send(32'h1c00001c, 1'b1, 5'd13, 1'b1, 3'd3, 32'h10000002, RD, 32'hFFFF80FF, w);
        send(32'h1c000020, 1'b1, 5'd14, 1'b1, 3'd4, 32'h10000000, RD, 32'h00007F01, w);
        send(32'h1c000024, 1'b1, 5'd15, 1'b1, 3'd0, 32'h10000000, RD, 32'h80FF7F01, w);
        send(32'h1c000028, 1'b1, 5'd16, 1'b1, 3'd6, 32'h10000003, RD, 32'h80FF7F01, w);
        send(32'h1c00002c, 1'b1, 5'd17, 1'b1, 3'd3, 32'h10000001, RD, 32'h00007F01, w);

        // r0 suppression
        send(32'h1c000030, 1'b1, 5'd0, 1'b0, 3'd0, 32'hDEADBEEF, 32'h0, 32'h0, w);
        @(negedge clk);
        check("r0_rf_we", {31'd0, rf_we}, 32'd0);
        check("r0_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
        check("r0_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
        check("r0_dbg_pc", debug_wb_pc, 32'h1c000030);
        @(posedge clk);
        #1;

        // Hold with a waiting offer
        send(32'h1c000040, 1'b1, 5'd7, 1'b0, 3'd0, 32'h00000777, 32'h0, 32'h00000777, w);
        ws_hold = 1'b1;
        set_inputs(32'h1c000044, 1'b1, 5'd9, 1'b0, 3'd0, 32'h00000999, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_allowin", {31'd0, ws_allowin}, 32'd0);
            check("hold_rf_we", {31'd0, rf_we}, 32'd0);
            check("hold_fwd", {26'd0, ws_fwd_valid, ws_fwd_dest}, 32'h27);
            check("hold_fwd_data", ws_fwd_data, 32'h00000777);
            @(posedge clk);
            #1;
        end
        ws_hold = 1'b0;
        @(negedge clk);
        check("release_allowin", {31'd0, ws_allowin}, 32'd1);
        check("release_rf_we", {31'd0, rf_we}, 32'd1);
        exp_q.push_back({32'h1c000044, 5'd9, 32'h00000999});
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
        @(negedge clk);
        check("after_hold_dest", {27'd0, rf_waddr}, 32'd9);
        @(posedge clk);
        #1;

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            send(32'h1c000100 + 32'(4 * i), 1'b1, 5'(i), 1'b0, 3'd0,
                 32'(i) * 32'h11, 32'h0, 32'(i) * 32'h11, w);
            check("stream_no_stall", 32'(w), 32'd0);
        end
        idle(2);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-hold
        send(32'h1c000200, 1'b1, 5'd12, 1'b0, 3'd0, 32'h0000CAFE, 32'h0, 32'h0000CAFE, w);
        void'(exp_q.pop_back());
        ws_hold = 1'b1;
        @(negedge clk);
        check("rsthold_fwd", {26'd0, ws_fwd_valid, ws_fwd_dest}, 32'h2c);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rsthold_rf_we", {31'd0, rf_we}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        ws_hold = 1'b0;
        @(negedge clk);
        check("rsthold_empty_pc", debug_wb_pc, 32'd0);
        check("rsthold_empty_fwd", {31'd0, ws_fwd_valid}, 32'd0);
        check("rsthold_allowin", {31'd0, ws_allowin}, 32'd1);
        check("rsthold_no_we", {31'd0, rf_we}, 32'd0);
        idle(3);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipeline. It accepts retiring instructions from the memory stage over a valid/allowin handshake, holds one instruction per cycle, and extracts and sign/zero-extends load data. It drives the register file's single write port, exports a forwarding tap to the decode stage, and emits the debug write-back trace.

## Interface

Parameters: none.

- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  memory stage offers an instruction
- ws_allowin  out  1  write-back can accept this cycle
- ms_pc  in  32  PC of offered instruction
- ms_gr_we  in  1  instruction writes a GPR
- ms_dest  in  5  destination GPR number
- ms_res_from_mem  in  1  result is load data (else ALU result)
- ms_ld_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5–7 treated as LW
- ms_alu_result  in  32  ALU result / load address (bits [1:0] select the byte lane)
- ms_mem_rdata  in  32  raw 32-bit word returned by data memory
- ws_hold  in  1  external stall (trace sink not ready); blocks retirement
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- ws_fwd_valid  out  1  write-back holds a pending GPR result
- ws_fwd_dest  out  5  its destination
- ws_fwd_data  out  32  its final data
- debug_wb_pc  out  32  PC of retiring instruction
- debug_wb_rf_we  out  4  byte write strobes (all-ones or zero)
- debug_wb_rf_wnum  out  5  destination GPR
- debug_wb_rf_wdata  out  32  written data

## Operation

- State: ws_valid plus registered copies of all ms_* fields (pc, gr_we, dest, res_from_mem, ld_type, alu_result, mem_rdata).
- ws_ready_go = !ws_hold. ws_allowin = !ws_valid || ws_ready_go.
- On accept (ms_to_ws_valid && ws_allowin):
  - Capture all fields.
  - ws_valid <= 1.
- Otherwise, if ws_ready_go: ws_valid <= 0.
- Otherwise: hold all state unchanged.
- Load extraction uses a = alu_result[1:0]:
  - byte = mem_rdata[8a+7:8a].
  - half = a[1] ? mem_rdata[31:16] : mem_rdata[15:0]; a[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- final_data = res_from_mem ? extracted load : alu_result.
- Write qualification: wr = ws_valid && gr_we && dest != 0.
- rf_we = wr && ws_ready_go. rf_waddr = dest. rf_wdata = final_data.
  - Writes to r0 are suppressed.
- Forwarding tap:
  - ws_fwd_valid = wr, independent of ws_hold, so that decode can bypass a held instruction.
  - ws_fwd_dest = dest. ws_fwd_data = final_data.
- Debug trace:
  - debug_wb_pc = ws_valid ? pc : 0.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = dest.
  - debug_wb_rf_wdata = final_data.
- Each instruction produces exactly one rf_we pulse and one debug trace cycle, in program order.

## Timing

- Reset: ws_valid = 0 and all captured fields = 0.
  - Every output is 0 except ws_allowin, which is 1.
- Accept edge N puts the instruction in WB during cycle N+1.
  - rf_we, the forwarding tap and debug outputs are combinational from the registered state in that cycle.
  - The register file commits at edge N+1 when ws_hold = 0.
- Throughput is one instruction per cycle with ws_hold low. Back-to-back accepts are allowed: retire and accept occur on the same edge.
- ws_hold high with ws_valid = 1:
  - ws_allowin = 0 and rf_we = 0.
  - The forwarding tap stays asserted.
  - State is frozen.
  - Upstream must keep its offer stable.
- ws_hold high with ws_valid = 0: ws_allowin = 1, so an instruction may enter.
- ms_to_ws_valid = 0 while retiring: the stage empties on the next cycle.
- Reset asserted mid-hold: the instruction is discarded with no write, and the stage is empty next cycle.
- Reset has priority over accept.

## Test plan

- **Reset and ALU write:** hold reset 2 cycles, then present an ALU op with pc = 0x1c000000, dest = 5, alu_result = 0x12345678 → all outputs 0 during reset. One cycle later: rf_we = 1, rf_waddr = 5, rf_wdata = 0x12345678, debug_wb_rf_we = 0xF.
- **Load extraction:** mem_rdata = 0x80FF7F01.
  - LB, a = 1 → 0x0000007F. LB, a = 2 → 0xFFFFFFFF.
  - LBU, a = 3 → 0x00000080.
  - LH, a = 2 → 0xFFFF80FF. LHU, a = 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- **r0 suppression:** gr_we = 1, dest = 0, alu_result = 0xDEADBEEF → rf_we = 0, ws_fwd_valid = 0, debug_wb_rf_we = 0; debug_wb_pc is still valid.
- **Hold:** instruction with dest = 7 in WB, ws_hold high for 3 cycles → ws_allowin = 0 and rf_we = 0 during the hold, ws_fwd_valid = 1 with dest 7 throughout. After release there is exactly one rf_we pulse, and the next offer is accepted on that same edge.
- **Streaming:** 8 back-to-back instructions with dest 1..8 and data = dest×0x11 → 8 consecutive rf_we cycles in order with the correct data, and ws_allowin constantly 1.
- **Reset mid-hold:** assert reset while a held instruction is in WB → no rf_we is ever issued for it, and ws_valid = 0 after reset.
